// File: rtl/adder_operand_ctrl.sv
// Purpose: collects operand A then operand B+carry-in from a byte stream, drives an external adder, registers sum/overflow.
// Latency: result registered one edge after B is accepted; result_valid high for the following cycle (DONE).
// Backpressure: none; data_valid is ignored (dropped, not queued) while busy is high in ADD and DONE.
module adder_operand_ctrl #(
    parameter int NUM_BITS = 8,
    parameter int CNT_BITS = 4
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic [NUM_BITS-1:0] data_in,
    input  logic                data_valid,
    input  logic                cin_in,
    input  logic                clear,
    input  logic [NUM_BITS-1:0] add_sum,
    input  logic                add_ovf,
    output logic [NUM_BITS-1:0] add_a,
    output logic [NUM_BITS-1:0] add_b,
    output logic                add_cin,
    output logic                busy,
    output logic [NUM_BITS-1:0] result,
    output logic                overflow,
    output logic                result_valid,
    output logic [CNT_BITS-1:0] overflow_cnt
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] WAIT_B = 2'd1;
    localparam logic [1:0] ADD    = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

    logic [1:0] state;
    logic [1:0] state_nxt;

    // Next-state decode; clear forces IDLE from any state.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (data_valid) state_nxt = WAIT_B;
                WAIT_B:  if (data_valid) state_nxt = ADD;
                ADD:     state_nxt = DONE;
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture: A in IDLE, B and carry-in together in WAIT_B; clear leaves them untouched.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            add_a   <= '0;
            add_b   <= '0;
            add_cin <= 1'b0;
        end else if (!clear && data_valid) begin
            if (state == IDLE) begin
                add_a <= data_in;
            end else if (state == WAIT_B) begin
                add_b   <= data_in;
                add_cin <= cin_in;
            end
        end
    end

    // Capture the adder outputs at the end of ADD unless the add is aborted by clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (!clear && state == ADD) begin
            result   <= add_sum;
            overflow <= add_ovf;
        end
    end

    // Saturating count of completed adds that overflowed; clear zeroes it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_cnt <= '0;
        end else if (clear) begin
            overflow_cnt <= '0;
        end else if (state == ADD && add_ovf && overflow_cnt != CNT_MAX) begin
            overflow_cnt <= overflow_cnt + CNT_BITS'(1);
        end
    end

    assign busy         = (state == ADD) || (state == DONE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_adder_operand_ctrl.sv
// Bench for adder_operand_ctrl with a behavioural 8-bit adder (overflow = carry out).
// Table-driven adds plus hand-written sequences for busy drop, saturation, clear and async reset.
module tb_adder_operand_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       cin_in;
    logic       clear;
    logic [7:0] add_sum;
    logic       add_ovf;
    logic [7:0] add_a;
    logic [7:0] add_b;
    logic       add_cin;
    logic       busy;
    logic [7:0] result;
    logic       overflow;
    logic       result_valid;
    logic [3:0] overflow_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External 8-bit adder: unsigned sum with carry out as overflow.
    assign {add_ovf, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

    adder_operand_ctrl #(.NUM_BITS(8), .CNT_BITS(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .cin_in       (cin_in),
        .clear        (clear),
        .add_sum      (add_sum),
        .add_ovf      (add_ovf),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_cin      (add_cin),
        .busy         (busy),
        .result       (result),
        .overflow     (overflow),
        .result_valid (result_valid),
        .overflow_cnt (overflow_cnt)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] res;
        logic       ovf;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Full add: A then B on consecutive cycles, then check the timing of result_valid and the captured values.
    task automatic do_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic [7:0] res, input logic ovf, input logic [3:0] cnt);
        data_valid = 1'b1;
        data_in    = a;
        cin_in     = 1'b0;
        tick();
        chk("add_a_loaded", {24'd0, add_a}, {24'd0, a});
        chk("busy_wait_b", {31'd0, busy}, 32'd0);
        data_in = b;
        cin_in  = cin;
        tick();
        data_valid = 1'b0;
        chk("busy_add", {31'd0, busy}, 32'd1);
        chk("rv_early", {31'd0, result_valid}, 32'd0);
        tick();
        chk("rv_pulse", {31'd0, result_valid}, 32'd1);
        chk("result", {24'd0, result}, {24'd0, res});
        chk("overflow", {31'd0, overflow}, {31'd0, ovf});
        chk("overflow_cnt", {28'd0, overflow_cnt}, {28'd0, cnt});
        tick();
        chk("rv_end", {31'd0, result_valid}, 32'd0);
        chk("busy_end", {31'd0, busy}, 32'd0);
    endtask

    logic seen_rv;

    initial begin
        vecs[0] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 4'd0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd1};
        vecs[2] = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 4'd2};
        vecs[3] = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 4'd3};
        vecs[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 4'd3};
        vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 4'd3};

        // Reset held with random inputs.
        n_rst      = 1'b0;
        clear      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        cin_in     = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in    = 8'($urandom);
            data_valid = 1'($urandom);
            cin_in     = 1'($urandom);
            tick();
        end
        chk("reset_outputs",
            {add_a, add_b, add_cin, busy, result, overflow, result_valid, overflow_cnt}, 32'd0);

        data_valid = 1'b0;
        data_in    = 8'h00;
        cin_in     = 1'b0;
        n_rst      = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_rv", {31'd0, result_valid}, 32'd0);

        // Table-driven adds.
        for (int i = 0; i < 6; i++) begin
            do_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].res, vecs[i].ovf, vecs[i].cnt);
        end

        // Busy drop with data_valid held high: 05,06 add; 07,08 dropped; 09 becomes next A.
        data_valid = 1'b1;
        cin_in     = 1'b0;
        data_in    = 8'h05; tick();
        data_in    = 8'h06; tick();
        data_in    = 8'h07; tick();
        chk("drop_result", {24'd0, result}, 32'h0B);
        chk("drop_rv", {31'd0, result_valid}, 32'd1);
        data_in    = 8'h08; tick();
        chk("drop_ops_held", {16'd0, add_a, add_b}, 32'h0506);
        chk("drop_idle", {31'd0, busy}, 32'd0);
        data_in    = 8'h09; tick();
        chk("drop_next_a", {24'd0, add_a}, 32'h09);
        data_in    = 8'h01; tick();
        data_valid = 1'b0;
        tick();
        chk("drop_second_result", {24'd0, result}, 32'h0A);

        tick();
        // Clear in IDLE zeroes the counter.
        clear = 1'b1; tick(); clear = 1'b0;
        chk("clear_idle_cnt", {28'd0, overflow_cnt}, 32'd0);

        // Seventeen overflowing adds saturate the counter at 15.
        for (int i = 0; i < 17; i++) begin
            do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, (i < 15) ? 4'(i + 1) : 4'd15);
        end
        chk("sat_cnt", {28'd0, overflow_cnt}, 32'd15);

        // Clear in WAIT_B: back to IDLE, counter zeroed, operand A kept, no result.
        data_valid = 1'b1;
        data_in    = 8'h33; tick();
        data_in    = 8'h44;
        clear      = 1'b1;
        tick();
        clear      = 1'b0;
        data_valid = 1'b0;
        chk("clr_wb_cnt", {28'd0, overflow_cnt}, 32'd0);
        chk("clr_wb_a_held", {24'd0, add_a}, 32'h33);
        chk("clr_wb_b_kept", {24'd0, add_b}, 32'h01);
        seen_rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_rv = seen_rv | result_valid | busy;
            tick();
        end
        chk("clr_wb_no_rv", {31'd0, seen_rv}, 32'd0);
        do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 4'd0);

        // Clear during ADD aborts the add.
        data_valid = 1'b1;
        data_in    = 8'hFF; tick();
        cin_in     = 1'b1; tick();
        data_valid = 1'b0;
        clear      = 1'b1; tick();
        clear      = 1'b0;
        cin_in     = 1'b0;
        chk("clr_add_result", {24'd0, result}, 32'h30);
        chk("clr_add_ovf", {31'd0, overflow}, 32'd0);
        chk("clr_add_cnt", {28'd0, overflow_cnt}, 32'd0);
        seen_rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            seen_rv = seen_rv | result_valid;
            tick();
        end
        chk("clr_add_no_rv", {31'd0, seen_rv}, 32'd0);

        // Async reset asserted off-edge while in ADD.
        data_valid = 1'b1;
        data_in    = 8'hAA; tick();
        data_in    = 8'hBB; tick();
        data_valid = 1'b0;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_outputs",
            {add_a, add_b, add_cin, busy, result, overflow, result_valid, overflow_cnt}, 32'd0);
        tick();
        tick();
        #3 n_rst = 1'b1;
        seen_rv = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen_rv = seen_rv | result_valid | busy;
        end
        chk("post_rst_no_rv", {31'd0, seen_rv}, 32'd0);
        chk("post_rst_result", {24'd0, result}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
